// File: rtl/config_pkg.sv
// Shared types and constants for the fabric configuration loader.
// Address field position and end-of-stream marker live here so readback blocks agree.
package config_pkg;

  typedef enum logic [1:0] {
    S_ADDR  = 2'd0,
    S_DATA  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] CFG_END_MARKER = 32'hFFFF_FFFF;
  localparam int          CFG_ADDR_LSB   = 0;
  localparam int          CFG_ADDR_W     = 16;

endpackage

// File: rtl/config_loader_if.sv
// Valid/ready stream carrying interleaved address and data words into the loader.
// The bitstream source drives the master side; the loader is the slave.
interface config_loader_if #(
  parameter int DATA_W = 32
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/onehot_decoder.sv
// Binary address to one-hot strobe, gated by an enable; all-zero when disabled or out of range.
// Purely combinational.
module onehot_decoder #(
  parameter int N      = 16,
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              en_i,
  output logic [N-1:0]      onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      if (en_i && (addr_i == ADDR_W'(i))) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/config_loader.sv
// Consumes (address, data) word pairs and issues one-cycle one-hot writes to tile config registers.
// One write per 3 cycles at best; in_ready drops during the write cycle and after the end marker.
module config_loader
  import config_pkg::*;
#(
  parameter int NUM_TILES = 16,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  config_loader_if.slave       in_if,
  output logic [DATA_W-1:0]    config_data,
  output logic [NUM_TILES-1:0] config_en,
  output logic                 done,
  output logic                 error,
  output logic [CNT_W-1:0]     words_written
);

  localparam logic [CFG_ADDR_W-1:0] MAX_ADDR = CFG_ADDR_W'(NUM_TILES - 1);

  state_e                  state_q, state_d;
  logic [CFG_ADDR_W-1:0]   addr_q, addr_d;
  logic                    drop_q, drop_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    ready_w;
  logic                    accept_w;
  logic                    write_w;
  logic [CFG_ADDR_W-1:0]   in_addr_w;

  // Reset gates ready and the strobe so an in-flight write is aborted in the reset cycle itself.
  assign ready_w   = ((state_q == S_ADDR) || (state_q == S_DATA)) && !reset;
  assign accept_w  = ready_w && in_if.in_valid;
  assign write_w   = (state_q == S_WRITE) && !drop_q && !reset;
  assign in_addr_w = in_if.in_data[CFG_ADDR_LSB +: CFG_ADDR_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ADDR;
      addr_q  <= '0;
      drop_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
      data_q  <= data_d;
      done_q  <= done_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drop_d  = drop_q;
    data_d  = data_q;
    done_d  = done_q;
    error_d = error_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_ADDR: begin
        if (accept_w) begin
          if (in_if.in_data == DATA_W'(CFG_END_MARKER)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            addr_d  = in_addr_w;
            state_d = S_DATA;
            if (in_addr_w > MAX_ADDR) begin
              error_d = 1'b1;
              drop_d  = 1'b1;
            end
          end
        end
      end
      S_DATA: begin
        if (accept_w) begin
          data_d  = in_if.in_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!drop_q && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + 1'b1;
        end
        drop_d  = 1'b0;
        state_d = S_ADDR;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_ADDR;
      end
    endcase
  end

  onehot_decoder #(
    .N      (NUM_TILES),
    .ADDR_W (CFG_ADDR_W)
  ) u_dec (
    .addr_i   (addr_q),
    .en_i     (write_w),
    .onehot_o (config_en)
  );

  assign in_if.in_ready = ready_w;
  assign config_data    = data_q;
  assign done           = done_q;
  assign error          = error_q;
  assign words_written  = cnt_q;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: each scenario task drives words at the falling edge
// and checks outputs at the following falling edge against hand-computed values.
module tb_config_loader;

  logic        clk;
  logic        reset;
  logic [31:0] config_data;
  logic [15:0] config_en;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  int tests_run;
  int tests_failed;

  config_loader_if #(.DATA_W(32)) in_if ();

  config_loader #(
    .NUM_TILES (16),
    .DATA_W    (32),
    .CNT_W     (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_if         (in_if),
    .config_data   (config_data),
    .config_en     (config_en),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic vld, input logic [31:0] dat);
    in_if.in_valid = vld;
    in_if.in_data  = dat;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0);
    tick();
    tick();
    tests_run++;
    if (in_if.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready_low: got %b want 0", in_if.in_ready);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (in_if.in_ready !== 1'b1 || config_en !== 16'h0 || done !== 1'b0 ||
        error !== 1'b0 || words_written !== 16'd0 || config_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_state: rdy=%b en=%h done=%b err=%b ww=%0d data=%h want 1 0000 0 0 0 0",
               in_if.in_ready, config_en, done, error, words_written, config_data);
    end
    tick();
    tests_run++;
    if (in_if.in_ready !== 1'b1 || config_en !== 16'h0) begin
      tests_failed++;
      $display("FAIL idle: rdy=%b en=%h want 1 0000", in_if.in_ready, config_en);
    end
  endtask

  task automatic test_stream();
    drive(1'b1, 32'h0000_0003);
    tick();
    drive(1'b1, 32'h0003_0000);
    tick();
    tests_run++;
    if (config_en !== 16'h0008 || config_data !== 32'h0003_0000 || in_if.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_write0: en=%h data=%h rdy=%b want 0008 00030000 0",
               config_en, config_data, in_if.in_ready);
    end
    drive(1'b1, 32'h0000_000F);
    tick();
    tests_run++;
    if (config_en !== 16'h0 || words_written !== 16'd1 || in_if.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL stream_after0: en=%h ww=%0d rdy=%b want 0000 1 1",
               config_en, words_written, in_if.in_ready);
    end
    tick();
    drive(1'b1, 32'hC000_0000);
    tick();
    tests_run++;
    if (config_en !== 16'h8000 || config_data !== 32'hC000_0000) begin
      tests_failed++;
      $display("FAIL stream_write1: en=%h data=%h want 8000 c0000000", config_en, config_data);
    end
    drive(1'b0, 32'h0);
    tick();
    tests_run++;
    if (config_en !== 16'h0 || words_written !== 16'd2 || config_data !== 32'hC000_0000) begin
      tests_failed++;
      $display("FAIL stream_count: en=%h ww=%0d data=%h want 0000 2 c0000000",
               config_en, words_written, config_data);
    end
  endtask

  task automatic test_valid_gap();
    drive(1'b1, 32'h0000_0005);
    tick();
    drive(1'b0, 32'h0000_0009);
    tick();
    tick();
    tests_run++;
    if (config_en !== 16'h0 || in_if.in_ready !== 1'b1 || config_data !== 32'hC000_0000) begin
      tests_failed++;
      $display("FAIL gap_hold: en=%h rdy=%b data=%h want 0000 1 c0000000",
               config_en, in_if.in_ready, config_data);
    end
    drive(1'b1, 32'hA5A5_0001);
    tick();
    tests_run++;
    if (config_en !== 16'h0020 || config_data !== 32'hA5A5_0001) begin
      tests_failed++;
      $display("FAIL gap_write: en=%h data=%h want 0020 a5a50001", config_en, config_data);
    end
    drive(1'b0, 32'h0);
    tick();
    tick();
    tests_run++;
    if (config_en !== 16'h0 || words_written !== 16'd3) begin
      tests_failed++;
      $display("FAIL gap_single: en=%h ww=%0d want 0000 3", config_en, words_written);
    end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 32'h0000_0010);
    tick();
    tests_run++;
    if (error !== 1'b1 || in_if.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL oor_error: err=%b rdy=%b want 1 1", error, in_if.in_ready);
    end
    drive(1'b1, 32'hDEAD_BEEF);
    tick();
    tests_run++;
    if (config_en !== 16'h0 || in_if.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL oor_no_pulse: en=%h rdy=%b want 0000 0", config_en, in_if.in_ready);
    end
    drive(1'b0, 32'h0);
    tick();
    tests_run++;
    if (words_written !== 16'd3 || error !== 1'b1) begin
      tests_failed++;
      $display("FAIL oor_count: ww=%0d err=%b want 3 1", words_written, error);
    end
    // Upper half of an address word is ignored: this targets tile 2.
    drive(1'b1, 32'hABCD_0002);
    tick();
    drive(1'b1, 32'h1111_2222);
    tick();
    tests_run++;
    if (config_en !== 16'h0004 || config_data !== 32'h1111_2222 || error !== 1'b1) begin
      tests_failed++;
      $display("FAIL oor_recover: en=%h data=%h err=%b want 0004 11112222 1",
               config_en, config_data, error);
    end
    drive(1'b0, 32'h0);
    tick();
    tests_run++;
    if (words_written !== 16'd4) begin
      tests_failed++;
      $display("FAIL oor_recover_count: ww=%0d want 4", words_written);
    end
  endtask

  task automatic test_marker_as_data();
    drive(1'b1, 32'h0000_0007);
    tick();
    drive(1'b1, 32'hFFFF_FFFF);
    tick();
    tests_run++;
    if (config_en !== 16'h0080 || config_data !== 32'hFFFF_FFFF || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL marker_data: en=%h data=%h done=%b want 0080 ffffffff 0",
               config_en, config_data, done);
    end
    drive(1'b0, 32'h0);
    tick();
    tests_run++;
    if (words_written !== 16'd5) begin
      tests_failed++;
      $display("FAIL marker_data_count: ww=%0d want 5", words_written);
    end
  endtask

  task automatic test_done();
    drive(1'b1, 32'hFFFF_FFFF);
    tick();
    tests_run++;
    if (done !== 1'b1 || in_if.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_set: done=%b rdy=%b want 1 0", done, in_if.in_ready);
    end
    drive(1'b1, 32'h0000_0001);
    tick();
    drive(1'b1, 32'h0000_0005);
    tick();
    tick();
    tests_run++;
    if (done !== 1'b1 || in_if.in_ready !== 1'b0 || config_en !== 16'h0 ||
        words_written !== 16'd5 || config_data !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL done_sticky: done=%b rdy=%b en=%h ww=%0d data=%h want 1 0 0000 5 ffffffff",
               done, in_if.in_ready, config_en, words_written, config_data);
    end
    drive(1'b0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if (done !== 1'b0 || in_if.in_ready !== 1'b1 || error !== 1'b0 || words_written !== 16'd0) begin
      tests_failed++;
      $display("FAIL done_reset: done=%b rdy=%b err=%b ww=%0d want 0 1 0 0",
               done, in_if.in_ready, error, words_written);
    end
  endtask

  task automatic test_reset_in_write();
    tick();
    drive(1'b1, 32'h0000_0001);
    tick();
    drive(1'b1, 32'h1234_5678);
    tick();
    tests_run++;
    if (config_en !== 16'h0002) begin
      tests_failed++;
      $display("FAIL rst_write_armed: en=%h want 0002", config_en);
    end
    drive(1'b0, 32'h0);
    reset = 1'b1;
    #1;
    tests_run++;
    if (config_en !== 16'h0 || in_if.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_write_abort: en=%h rdy=%b want 0000 0", config_en, in_if.in_ready);
    end
    tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if (words_written !== 16'd0 || config_data !== 32'h0 || config_en !== 16'h0 ||
        in_if.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_write_after: ww=%0d data=%h en=%h rdy=%b want 0 0 0000 1",
               words_written, config_data, config_en, in_if.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h0000_0000);
    tick();
    drive(1'b1, 32'h0000_00AA);
    tick();
    tests_run++;
    if (config_en !== 16'h0001 || config_data !== 32'h0000_00AA) begin
      tests_failed++;
      $display("FAIL b2b_w0: en=%h data=%h want 0001 000000aa", config_en, config_data);
    end
    drive(1'b1, 32'h0000_000C);
    tick();
    tick();
    drive(1'b1, 32'h0000_00BB);
    tick();
    tests_run++;
    if (config_en !== 16'h1000 || config_data !== 32'h0000_00BB) begin
      tests_failed++;
      $display("FAIL b2b_w1: en=%h data=%h want 1000 000000bb", config_en, config_data);
    end
    drive(1'b0, 32'h0);
    tick();
    tests_run++;
    if (words_written !== 16'd2 || config_en !== 16'h0) begin
      tests_failed++;
      $display("FAIL b2b_count: ww=%0d en=%h want 2 0000", words_written, config_en);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    drive(1'b0, 32'h0);
    test_reset();
    test_stream();
    test_valid_gap();
    test_out_of_range();
    test_marker_as_data();
    test_done();
    test_reset_in_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
